dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7, word-index width of data memory (128 words).
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter STARVE_MAX, default 4, consecutive CPU wins tolerated while loader waits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-006 cpu_req  input  1  MEM-stage access request (MemRead or MemWrite).
REQ-007 cpu_we  input  1  1 = write, 0 = read.
REQ-008 cpu_addr  input  32  byte address from ALU output; only [ADDR_W-1:0] used as word index.
REQ-009 cpu_wdata  input  DATA_W  store data.
REQ-010 ld_req, ld_we  input  1 each  loader/debug port request and write enable.
REQ-011 ld_addr  input  ADDR_W  loader word index.
REQ-012 ld_wdata  input  DATA_W  loader store data.
REQ-013 ld_lock  input  1  loader requests exclusive memory ownership.
REQ-014 cpu_gnt, ld_gnt  output  1 each  combinational grant for current cycle.
REQ-015 cpu_stall  output  1  pipeline stall = cpu_req & ~cpu_gnt.
REQ-016 cpu_rdata, ld_rdata  output  DATA_W  registered read data.
REQ-017 cpu_rvalid, ld_rvalid  output  1 each  one-cycle pulse, read data valid.
REQ-018 locked  output  1  high while FSM in S_LOCK.

Function
REQ-019 FSM states SHALL be S_RUN (shared arbitration) and S_LOCK (loader exclusive).
REQ-020 At most one of cpu_gnt/ld_gnt SHALL be high in any cycle; grant requires matching req.
REQ-021 In S_RUN, CPU SHALL win when both request, unless starve_cnt == STARVE_MAX, then loader wins.
REQ-022 starve_cnt SHALL increment when CPU wins with ld_req high, clear when ld_gnt or ld_req low, saturate at STARVE_MAX.
REQ-023 S_RUN -> S_LOCK SHALL occur on the edge where ld_lock=1 and cpu_gnt=0 in that cycle.
REQ-024 In S_LOCK, cpu_gnt SHALL be 0 (cpu_stall follows cpu_req); ld_gnt = ld_req.
REQ-025 S_LOCK -> S_RUN SHALL occur on the edge where ld_lock=0; starve_cnt cleared on exit.
REQ-026 Granted write SHALL update memory at that cycle's rising edge.
REQ-027 Granted read SHALL load the requester's rdata at the edge and pulse its rvalid the following cycle; latency 1.
REQ-028 Non-granted or idle cycles SHALL hold rdata and deassert rvalid.
REQ-029 Write then read of same index on consecutive cycles SHALL return new data.
REQ-030 cpu_addr bits above ADDR_W-1 SHALL be ignored (index wraps modulo 128).
REQ-031 Requesters SHALL hold req/addr/data stable until granted; arbiter SHALL not queue.

Reset
REQ-032 While rst=0: state S_RUN, starve_cnt 0, cpu_rdata/ld_rdata 0, cpu_rvalid/ld_rvalid 0, locked 0.
REQ-033 Grants SHALL be 0 while rst=0, regardless of requests.
REQ-034 Reset mid-read SHALL cancel the pending rvalid; memory contents are not reset.

Structure
REQ-035 Shared package SHALL hold state encoding (S_RUN, S_LOCK) and default ADDR_W/DATA_W.
REQ-036 Storage SHALL be one sub-module dmem_ram: single-port, sync write, sync read, 2^ADDR_W x DATA_W.
REQ-037 Arbiter/FSM logic and starve_cnt SHALL live in dmem_arbiter only.

Verification
REQ-038 CPU write 0xDEADBEEF at addr 0x104, then read 0x004 -> cpu_rvalid next cycle, cpu_rdata 0xDEADBEEF.
REQ-039 Both requesting continuously -> CPU wins 4 cycles, loader 5th, pattern repeats; never both grants.
REQ-040 ld_lock=1 while CPU idle -> locked=1 next cycle; cpu_req then gives cpu_stall=1 until ld_lock=0 plus one edge.
REQ-041 ld_lock=1 while CPU granted -> lock entry deferred until a cycle with cpu_gnt=0.
REQ-042 rst=0 asserted during granted read -> rvalid 0, rdata 0, locked 0 immediately; previously written data still readable after release.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and
// default memory geometry.
package dmem_arbiter_pkg;

  // Default word-index width (128 words) and data width.
  localparam int DMEM_ADDR_W     = 7;
  localparam int DMEM_DATA_W     = 32;
  // Default number of consecutive CPU wins tolerated while the loader waits.
  localparam int DMEM_STARVE_MAX = 4;

  // S_RUN: CPU and loader share the memory. S_LOCK: loader owns it.
  typedef enum logic {
    S_RUN  = 1'b0,
    S_LOCK = 1'b1
  } arb_state_e;

endpackage : dmem_arbiter_pkg

// File: rtl/dmem_ram.sv
// Single-port data memory: synchronous write, synchronous read.
// Contents are not reset; the read register only updates on a read access.
module dmem_ram
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  // Write on an enabled write access, capture read data on an enabled read.
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : dmem_ram

// File: rtl/dmem_arbiter.sv
// Arbiter between the CPU MEM stage and a loader/debug port for one shared
// single-port data memory. CPU has priority, bounded by a starvation counter;
// the loader can also take exclusive ownership via ld_lock.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int STARVE_MAX = DMEM_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_lock,
  output logic              cpu_gnt,
  output logic              ld_gnt,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              cpu_rvalid,
  output logic              ld_rvalid,
  output logic              locked
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_e        state_q;
  logic              locked_q;
  logic [SW-1:0]     starve_q, starve_d;
  logic              starve_hit;
  logic              cpu_win, ld_win;
  logic              cpu_rvalid_q, ld_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q, ld_rdata_q;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              unused_cpu_addr_hi;

  // Byte-address bits above the word index are deliberately ignored.
  assign unused_cpu_addr_hi = ^cpu_addr[31:ADDR_W];

  assign starve_hit = (starve_q == STARVE_LIM);

  // Grant selection: nothing in reset, loader only when locked, otherwise
  // CPU first unless the loader has waited STARVE_MAX consecutive CPU wins.
  always_comb begin
    cpu_win = 1'b0;
    ld_win  = 1'b0;
    if (rst) begin
      if (state_q == S_LOCK) begin
        ld_win = ld_req;
      end else if (ld_req && (!cpu_req || starve_hit)) begin
        ld_win = 1'b1;
      end else begin
        cpu_win = cpu_req;
      end
    end
  end

  // Starvation count: counts CPU wins over a waiting loader, saturating.
  always_comb begin
    starve_d = starve_q;
    if (ld_win || !ld_req) begin
      starve_d = '0;
    end else if (cpu_win && !starve_hit) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Ownership FSM with registered locked flag, plus starvation counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_RUN;
      locked_q <= 1'b0;
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
      if (state_q == S_RUN) begin
        if (ld_lock && !cpu_win) begin
          state_q  <= S_LOCK;
          locked_q <= 1'b1;
        end
      end else begin
        if (!ld_lock) begin
          state_q  <= S_RUN;
          locked_q <= 1'b0;
          starve_q <= '0;
        end
      end
    end
  end

  // Single memory port driven by whichever requester holds the grant.
  assign ram_en    = cpu_win | ld_win;
  assign ram_we    = ld_win ? ld_we    : cpu_we;
  assign ram_addr  = ld_win ? ld_addr  : cpu_addr[ADDR_W-1:0];
  assign ram_wdata = ld_win ? ld_wdata : cpu_wdata;

  dmem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Read-valid pulses, and per-requester hold registers. While a requester's
  // rvalid is high its data is the RAM read register itself; on the next edge
  // that value is copied into the hold register before the RAM register can
  // be overwritten by another access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rvalid_q <= 1'b0;
      ld_rvalid_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      ld_rdata_q   <= '0;
    end else begin
      if (cpu_rvalid_q) begin
        cpu_rdata_q <= ram_rdata;
      end
      if (ld_rvalid_q) begin
        ld_rdata_q <= ram_rdata;
      end
      cpu_rvalid_q <= cpu_win & ~cpu_we;
      ld_rvalid_q  <= ld_win & ~ld_we;
    end
  end

  assign cpu_gnt    = cpu_win;
  assign ld_gnt     = ld_win;
  assign cpu_stall  = cpu_req & ~cpu_win;
  assign cpu_rvalid = cpu_rvalid_q;
  assign ld_rvalid  = ld_rvalid_q;
  assign cpu_rdata  = cpu_rvalid_q ? ram_rdata : cpu_rdata_q;
  assign ld_rdata   = ld_rvalid_q  ? ram_rdata : ld_rdata_q;
  assign locked     = locked_q;

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a behavioural model checked against
// the DUT on every falling edge, plus directed scenarios with literal values.
module tb_dmem_arbiter;

  localparam int AW   = 7;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [31:0]   cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          ld_req, ld_we, ld_lock;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          cpu_gnt, ld_gnt, cpu_stall, cpu_rvalid, ld_rvalid, locked;
  logic [DW-1:0] cpu_rdata, ld_rdata;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .ld_req     (ld_req),
    .ld_we      (ld_we),
    .ld_addr    (ld_addr),
    .ld_wdata   (ld_wdata),
    .ld_lock    (ld_lock),
    .cpu_gnt    (cpu_gnt),
    .ld_gnt     (ld_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rdata  (cpu_rdata),
    .ld_rdata   (ld_rdata),
    .cpu_rvalid (cpu_rvalid),
    .ld_rvalid  (ld_rvalid),
    .locked     (locked)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model state.
  logic [DW-1:0] m_mem [0:(1<<AW)-1];
  bit            m_lock;
  int            m_wins;
  bit            e_crv, e_lrv;
  logic [DW-1:0] e_crd, e_lrd;
  bit            g_c, g_l;

  initial begin
    for (int i = 0; i < (1<<AW); i++) m_mem[i] = '0;
    m_lock = 0; m_wins = 0; e_crv = 0; e_lrv = 0; e_crd = '0; e_lrd = '0;
  end

  // Model and compare on the falling edge; inputs are stable here until the
  // next rising edge, so the model may also advance to its post-edge state.
  always @(negedge clk) begin
    g_c = 0;
    g_l = 0;
    if (!rst) begin
      m_lock = 0; m_wins = 0; e_crv = 0; e_lrv = 0; e_crd = '0; e_lrd = '0;
    end else if (m_lock) begin
      g_l = ld_req;
    end else if (cpu_req && ld_req) begin
      if (m_wins >= SMAX) g_l = 1;
      else                g_c = 1;
    end else begin
      g_c = cpu_req;
      g_l = ld_req;
    end

    chk1("cpu_gnt", cpu_gnt, g_c);
    chk1("ld_gnt", ld_gnt, g_l);
    chk1("one_grant", cpu_gnt & ld_gnt, 1'b0);
    chk1("cpu_stall", cpu_stall, cpu_req & ~g_c);
    chk1("locked", locked, m_lock);
    chk1("cpu_rvalid", cpu_rvalid, e_crv);
    chk1("ld_rvalid", ld_rvalid, e_lrv);
    chkw("cpu_rdata", cpu_rdata, e_crd);
    chkw("ld_rdata", ld_rdata, e_lrd);

    if (rst) begin
      e_crv = g_c && !cpu_we;
      e_lrv = g_l && !ld_we;
      if (g_c) begin
        if (cpu_we) m_mem[cpu_addr % (1<<AW)] = cpu_wdata;
        else        e_crd = m_mem[cpu_addr % (1<<AW)];
      end
      if (g_l) begin
        if (ld_we) m_mem[ld_addr] = ld_wdata;
        else       e_lrd = m_mem[ld_addr];
      end
      if (g_c && ld_req) m_wins = (m_wins < SMAX) ? m_wins + 1 : SMAX;
      else               m_wins = 0;
      if (!m_lock && ld_lock && !g_c) begin
        m_lock = 1;
      end else if (m_lock && !ld_lock) begin
        m_lock = 0;
        m_wins = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  string seq;

  initial begin
    rst = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0; ld_lock = 0;

    // Requests during reset are never granted.
    step();
    cpu_req = 1; ld_req = 1;
    #1;
    chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
    chk1("rst_ld_gnt", ld_gnt, 1'b0);
    chk1("rst_locked", locked, 1'b0);
    step();
    cpu_req = 0; ld_req = 0; rst = 1'b1;
    step();

    // CPU write at 0x104, read back through 0x004 (same word index).
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h104; cpu_wdata = 32'hDEADBEEF;
    step();
    cpu_we = 0; cpu_addr = 32'h004;
    step();
    cpu_req = 0;
    chk1("wrap_rvalid", cpu_rvalid, 1'b1);
    chkw("wrap_rdata", cpu_rdata, 32'hDEADBEEF);
    step();
    chk1("rvalid_pulse", cpu_rvalid, 1'b0);
    chkw("rdata_hold", cpu_rdata, 32'hDEADBEEF);

    // Fill a few words from both ports.
    for (int i = 0; i < 4; i++) begin
      ld_req = 1; ld_we = 1; ld_addr = AW'(8 + i); ld_wdata = 32'hA000_0000 + i;
      step();
    end
    ld_req = 0; ld_we = 0;
    for (int i = 0; i < 4; i++) begin
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'(16 + i); cpu_wdata = 32'hC000_0000 + i;
      step();
    end
    cpu_req = 0; cpu_we = 0;

    // Continuous contention: four CPU wins, then one loader win.
    cpu_req = 1; cpu_addr = 32'd16; ld_req = 1; ld_we = 0; ld_addr = 7'd8;
    seq = "";
    for (int i = 0; i < 10; i++) begin
      #2;
      if (cpu_gnt && ld_gnt) seq = {seq, "B"};
      else if (cpu_gnt)      seq = {seq, "C"};
      else if (ld_gnt)       seq = {seq, "L"};
      else                   seq = {seq, "-"};
      @(posedge clk);
      #1;
    end
    ntests++;
    if (seq != "CCCCLCCCCL") begin
      nfail++;
      $display("FAIL grant_pattern: got %s, expected CCCCLCCCCL", seq);
    end
    cpu_req = 0; ld_req = 0;
    step();

    // Lock taken while the CPU is idle; CPU then stalls.
    ld_lock = 1;
    step();
    chk1("lock_enter", locked, 1'b1);
    cpu_req = 1; cpu_addr = 32'd16;
    ld_req = 1; ld_we = 1; ld_addr = 7'd9; ld_wdata = 32'h5555_0009;
    #1;
    chk1("lock_stall", cpu_stall, 1'b1);
    chk1("lock_no_cpu_gnt", cpu_gnt, 1'b0);
    chk1("lock_ld_gnt", ld_gnt, 1'b1);
    step();
    ld_we = 0;
    step();
    chk1("lock_ld_rvalid", ld_rvalid, 1'b1);
    chkw("lock_ld_rdata", ld_rdata, 32'h5555_0009);
    ld_req = 0;
    step();
    ld_lock = 0;
    #1;
    chk1("lock_still", locked, 1'b1);
    chk1("lock_stall_last", cpu_stall, 1'b1);
    step();
    chk1("lock_exit", locked, 1'b0);
    chk1("exit_stall", cpu_stall, 1'b0);
    step();
    cpu_req = 0;
    chkw("exit_cpu_rdata", cpu_rdata, 32'hC000_0000);

    // Lock requested while the CPU holds the grant: deferred.
    cpu_req = 1; cpu_addr = 32'd17; ld_lock = 1;
    step();
    chk1("lock_defer1", locked, 1'b0);
    step();
    chk1("lock_defer2", locked, 1'b0);
    cpu_req = 0;
    step();
    chk1("lock_after_defer", locked, 1'b1);

    // Reset asserted while a loader read is being returned.
    ld_req = 1; ld_we = 0; ld_addr = 7'd4;
    step();
    chk1("pre_rst_rvalid", ld_rvalid, 1'b1);
    chkw("pre_rst_rdata", ld_rdata, 32'hDEADBEEF);
    rst = 1'b0;
    #1;
    chk1("rst_ld_rvalid", ld_rvalid, 1'b0);
    chkw("rst_ld_rdata", ld_rdata, 32'h0);
    chk1("rst_unlock", locked, 1'b0);
    ld_req = 0; ld_lock = 0;
    step();
    rst = 1'b1;
    step();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'hFFFF_FF84;
    step();
    cpu_req = 0;
    chkw("mem_survives_rst", cpu_rdata, 32'hDEADBEEF);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule : tb_dmem_arbiter
